uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an integrated transmit FIFO and a valid/ready input handshake. It supports configurable data width, parity mode and stop-bit count. Upstream logic, such as the SD-card read path or a debug/status streamer, pushes words without tracking per-frame timing. The block drains the FIFO back-to-back onto a single `tx` line.

---
 rtl/uart_tx_fifo.sv | 213 +++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small synchronous FIFO with a valid/ready input.
// Frames are drained back-to-back: start, data LSB first, optional parity, stop.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 20_000_000,
  parameter int UART_BPS   = 921600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BAUD_DIV = (CLK_FREQ + UART_BPS / 2) / UART_BPS;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int LVL_W    = PTR_W + 1;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_fifo: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
    end
    if (BAUD_DIV < 1) begin : g_bad_baud
      $error("uart_tx_fifo: UART_BPS too high for CLK_FREQ");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] rd_data_q;

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 s_ready_q, s_ready_d;
  logic                 avail_q, avail_d;
  logic                 push, pop;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 baud_last;

  assign push = s_valid && s_ready_q;

  // Storage has no reset; the read port is registered so it maps onto block RAM.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr_q] <= s_data;
    end
    rd_data_q <= mem[rd_ptr_q];
  end

  // avail lags level by one cycle, matching the write-to-registered-read turnaround,
  // so rd_data_q always holds the head word whenever avail_q is set.
  always_comb begin
    wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    level_d   = level_q + LVL_W'(push) - LVL_W'(pop);
    s_ready_d = (level_d != LVL_W'(FIFO_DEPTH));
    avail_d   = (level_q != '0);
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    baud_last  = (baud_cnt_q == CNT_W'(BAUD_DIV - 1));

    if (state_q != ST_IDLE) begin
      baud_cnt_d = baud_last ? '0 : baud_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (avail_q) begin
          pop        = 1'b1;
          state_d    = ST_START;
          shift_d    = rd_data_q;
          parity_d   = (PARITY == 1) ? ~^rd_data_q : ^rd_data_q;
          tx_d       = 1'b0;
          baud_cnt_d = '0;
        end
      end
      ST_START: begin
        if (baud_last) begin
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            if (PARITY != 0) begin
              state_d = ST_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_last) begin
          state_d   = ST_STOP;
          tx_d      = 1'b1;
          bit_cnt_d = '0;
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
            // Chain straight into the next frame when a word is waiting.
            if (avail_q) begin
              pop        = 1'b1;
              state_d    = ST_START;
              shift_d    = rd_data_q;
              parity_d   = (PARITY == 1) ? ~^rd_data_q : ^rd_data_q;
              tx_d       = 1'b0;
              baud_cnt_d = '0;
            end else begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    busy_d = (state_d != ST_IDLE) || (level_d != '0);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      s_ready_q  <= 1'b1;
      avail_q    <= 1'b0;
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      s_ready_q  <= s_ready_d;
      avail_q    <= avail_d;
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four frame formats share clock and reset,
// one monitor mux selects which instance is being checked.
module tb_uart_tx_fifo;

  localparam int BAUD = 22;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [7:0] din       = '0;
  logic [3:0] sv        = '0;
  logic [3:0] tx_w, busy_w, rdy_w;
  logic [4:0] lvl_w [4];
  logic [1:0] mon_sel   = 2'd0;

  logic       tx_mon, busy_mon, rdy_mon;
  logic [4:0] lvl_mon;

  int checks   = 0;
  int failures = 0;
  int acc      = 0;
  int seen     = 0;
  int saw_low  = 0;

  always #5 sys_clk = ~sys_clk;

  assign tx_mon   = tx_w[mon_sel];
  assign busy_mon = busy_w[mon_sel];
  assign rdy_mon  = rdy_w[mon_sel];
  assign lvl_mon  = lvl_w[mon_sel];

  uart_tx_fifo u_8n1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .s_data(din), .s_valid(sv[0]),
    .s_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .fifo_level(lvl_w[0])
  );

  uart_tx_fifo #(.PARITY(2)) u_8e1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .s_data(din), .s_valid(sv[1]),
    .s_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .fifo_level(lvl_w[1])
  );

  uart_tx_fifo #(.PARITY(1)) u_8o1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .s_data(din), .s_valid(sv[2]),
    .s_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .fifo_level(lvl_w[2])
  );

  uart_tx_fifo #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .s_data(din[6:0]), .s_valid(sv[3]),
    .s_ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .fifo_level(lvl_w[3])
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at the first sample of the start bit; checks both ends of every bit
  // and returns at the first sample after the frame.
  task automatic check_frame(input string name, input logic [15:0] bits, input int nbits);
    for (int b = 0; b < nbits; b++) begin
      for (int o = 0; o < BAUD; o++) begin
        if (o == 0 || o == BAUD - 1) begin
          chk($sformatf("%s_bit%0d_off%0d", name, b, o), 32'(tx_mon), 32'(bits[b]));
        end
        if (b == nbits - 1 && o == BAUD - 1) begin
          chk($sformatf("%s_busy_last", name), 32'(busy_mon), 1);
        end
        @(negedge sys_clk);
      end
    end
    $display("frame %s: %0d bits checked, checks=%0d failures=%0d", name, nbits, checks, failures);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while (busy_mon && n < limit) begin
      @(negedge sys_clk);
      n++;
    end
    chk($sformatf("%s_idle_busy", name), 32'(busy_mon), 0);
    chk($sformatf("%s_idle_level", name), 32'(lvl_mon), 0);
    chk($sformatf("%s_idle_tx", name), 32'(tx_mon), 1);
  endtask

  initial begin
    // Reset values on every instance
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    for (int i = 0; i < 4; i++) begin
      mon_sel = 2'(i);
      #1;
      chk($sformatf("rst%0d_tx", i), 32'(tx_mon), 1);
      chk($sformatf("rst%0d_ready", i), 32'(rdy_mon), 1);
      chk($sformatf("rst%0d_busy", i), 32'(busy_mon), 0);
      chk($sformatf("rst%0d_level", i), 32'(lvl_mon), 0);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // 8N1, 0xA5: latency of two edges, then 10 x 22 cycles
    mon_sel = 2'd0;
    din = 8'hA5;
    sv[0] = 1'b1;
    @(negedge sys_clk);
    sv = '0;
    chk("8n1_level_after_push", 32'(lvl_mon), 1);
    chk("8n1_busy_after_push", 32'(busy_mon), 1);
    chk("8n1_tx_edge_n", 32'(tx_mon), 1);
    @(negedge sys_clk);
    chk("8n1_tx_edge_n1", 32'(tx_mon), 1);
    @(negedge sys_clk);
    check_frame("8n1_a5", 16'b0000001101001010, 10);
    chk("8n1_busy_after_frame", 32'(busy_mon), 0);
    chk("8n1_tx_after_frame", 32'(tx_mon), 1);

    // 8E1 and 8O1, 0xA5: parity 0 then 1
    mon_sel = 2'd1;
    sv[1] = 1'b1;
    @(negedge sys_clk);
    sv = '0;
    repeat (2) @(negedge sys_clk);
    check_frame("8e1_a5", 16'b0000010101001010, 11);
    chk("8e1_busy_after_frame", 32'(busy_mon), 0);

    mon_sel = 2'd2;
    sv[2] = 1'b1;
    @(negedge sys_clk);
    sv = '0;
    repeat (2) @(negedge sys_clk);
    check_frame("8o1_a5", 16'b0000011101001010, 11);
    chk("8o1_busy_after_frame", 32'(busy_mon), 0);

    // 7O2, 0x41: 0,1,0,0,0,0,0,1,1,1,1
    mon_sel = 2'd3;
    din = 8'h41;
    sv[3] = 1'b1;
    @(negedge sys_clk);
    sv = '0;
    repeat (2) @(negedge sys_clk);
    check_frame("7o2_41", 16'b0000011110000010, 11);
    chk("7o2_busy_after_frame", 32'(busy_mon), 0);

    // Push and pop on the same edge at level 5
    mon_sel = 2'd0;
    for (int i = 0; i < 6; i++) begin
      din = 8'h30 + 8'(i);
      sv[0] = 1'b1;
      chk($sformatf("pp_ready_%0d", i), 32'(rdy_mon), 1);
      @(negedge sys_clk);
    end
    sv = '0;
    chk("pp_level5", 32'(lvl_mon), 5);
    repeat (216) @(negedge sys_clk);
    chk("pp_last_stop_tx", 32'(tx_mon), 1);
    din = 8'h40;
    sv[0] = 1'b1;
    @(negedge sys_clk);
    sv = '0;
    chk("pp_level_same", 32'(lvl_mon), 5);
    chk("pp_ready", 32'(rdy_mon), 1);
    check_frame("pp_w31", 16'({1'b1, 8'h31, 1'b0}), 10);
    wait_idle("pp", 2000);

    // Continuous s_valid from idle: 17 accepted, level peaks at 16
    acc = 0;
    din = 8'h00;
    sv[0] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (rdy_mon) acc++;
      @(negedge sys_clk);
      din = 8'(acc);
    end
    chk("full_accepted", acc, 17);
    chk("full_level", 32'(lvl_mon), 16);
    chk("full_ready", 32'(rdy_mon), 0);
    seen = 0;
    for (int c = 0; c < 400 && seen == 0; c++) begin
      @(negedge sys_clk);
      if (rdy_mon) seen = 1;
    end
    sv = '0;
    chk("full_ready_returns", seen, 1);
    chk("full_level_after_pop", 32'(lvl_mon), 15);
    check_frame("full_w1", 16'({1'b1, 8'h01, 1'b0}), 10);
    check_frame("full_w2", 16'({1'b1, 8'h02, 1'b0}), 10);
    wait_idle("full", 4000);

    // Reset during data bit 3 of the first of three frames
    for (int i = 0; i < 3; i++) begin
      din = 8'h50 + 8'(i);
      sv[0] = 1'b1;
      @(negedge sys_clk);
    end
    sv = '0;
    chk("rstmid_start_tx", 32'(tx_mon), 0);
    repeat (95) @(negedge sys_clk);
    chk("rstmid_bit3_tx", 32'(tx_mon), 0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("rstmid_tx", 32'(tx_mon), 1);
    chk("rstmid_level", 32'(lvl_mon), 0);
    chk("rstmid_busy", 32'(busy_mon), 0);
    chk("rstmid_ready", 32'(rdy_mon), 1);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    saw_low = 0;
    repeat (100) begin
      @(negedge sys_clk);
      if (!tx_mon) saw_low = 1;
    end
    chk("rstmid_line_quiet", saw_low, 0);
    chk("rstmid_post_busy", 32'(busy_mon), 0);
    chk("rstmid_post_level", 32'(lvl_mon), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
